// File: rtl/control_fsm.sv
// control_fsm: multi-cycle control unit for the 9-bit datapath.
// Latches each instruction in FETCH, walks it through DECODE/EXEC/MEM/WB,
// decodes datapath controls from state and IR, handshakes with data memory,
// and keeps a retired-instruction count plus a sticky overflow flag.
module control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] inst,
  input  logic       BranchFlag,
  input  logic       overflow,
  input  logic       mem_ack,
  output logic       MemToReg,
  output logic       PcSrc,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic       Jump,
  output logic [2:0] ALUControl,
  output logic [2:0] AccControl,
  output logic       PcWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       halted,
  output logic       ovf_flag,
  output logic [7:0] retired
);

  localparam int unsigned IW = 9;
  localparam int unsigned CW = 3;
  localparam int unsigned RW = 8;

  localparam logic [CW-1:0] OP_ADD    = 3'b000;
  localparam logic [CW-1:0] OP_SUB    = 3'b001;
  localparam logic [CW-1:0] OP_JUMP   = 3'b010;
  localparam logic [CW-1:0] OP_BRANCH = 3'b011;
  localparam logic [CW-1:0] OP_LOAD   = 3'b100;
  localparam logic [CW-1:0] OP_STORE  = 3'b101;
  localparam logic [CW-1:0] OP_ADDI   = 3'b110;
  localparam logic [CW-1:0] OP_SYS    = 3'b111;

  localparam logic [CW-1:0] ALU_ADD = 3'b010;
  localparam logic [CW-1:0] ALU_SUB = 3'b110;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_ir;
  logic            r_ovf;
  logic [RW-1:0]   r_retired;

  logic [CW-1:0]   w_op;
  logic            w_arith;
  logic            w_load;
  logic            w_store;
  logic            w_halt_op;
  logic            w_acc_op;
  logic [CW-1:0]   w_alu_ctl;
  logic            w_alu_src;

  assign w_op      = r_ir[8:6];
  assign w_load    = (w_op == OP_LOAD);
  assign w_store   = (w_op == OP_STORE);
  assign w_arith   = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_ADDI);
  assign w_halt_op = (w_op == OP_SYS) && (r_ir[5:0] == 6'b000000);
  assign w_acc_op  = (w_op == OP_SYS) && (r_ir[5:3] == 3'b001);
  assign w_alu_src = (w_op == OP_ADDI) || w_load || w_store;
  assign w_alu_ctl = (w_op == OP_SUB) ? ALU_SUB :
                     (w_arith || w_load || w_store) ? ALU_ADD : 3'b000;

  assign ovf_flag = r_ovf;
  assign retired  = r_retired;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Instruction register, loaded only while fetching
  always_ff @(posedge clk) begin
    if (rst)                     r_ir <= '0;
    else if (r_state == S_FETCH) r_ir <= inst;
  end

  // Sticky overflow from arithmetic EXEC cycles
  always_ff @(posedge clk) begin
    if (rst)                                         r_ovf <= 1'b0;
    else if ((r_state == S_EXEC) && w_arith && overflow) r_ovf <= 1'b1;
  end

  // Retired-instruction counter, one step per PC update, wraps naturally
  always_ff @(posedge clk) begin
    if (rst)          r_retired <= '0;
    else if (PcWrite) r_retired <= r_retired + RW'(1);
  end

  // Next-state and control decode
  always_comb begin
    w_next     = r_state;
    MemToReg   = 1'b0;
    PcSrc      = 1'b0;
    ALUSrc     = 1'b0;
    RegWrite   = 1'b0;
    Jump       = 1'b0;
    ALUControl = 3'b000;
    AccControl = 3'b000;
    PcWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    halted     = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUControl = w_alu_ctl;
        ALUSrc     = w_alu_src;
        w_next     = w_halt_op ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        ALUControl = w_alu_ctl;
        ALUSrc     = w_alu_src;
        case (w_op)
          OP_JUMP: begin
            Jump    = 1'b1;
            PcWrite = 1'b1;
            w_next  = S_FETCH;
          end
          OP_BRANCH: begin
            PcSrc   = BranchFlag;
            PcWrite = 1'b1;
            w_next  = S_FETCH;
          end
          OP_LOAD, OP_STORE: begin
            w_next = S_MEM;
          end
          OP_SYS: begin
            if (w_acc_op) AccControl = r_ir[2:0];
            PcWrite = 1'b1;
            w_next  = S_FETCH;
          end
          default: begin
            w_next = S_WB;
          end
        endcase
      end
      S_MEM: begin
        ALUControl = w_alu_ctl;
        ALUSrc     = w_alu_src;
        MemRead    = w_load;
        MemWrite   = w_store;
        if (mem_ack) begin
          PcWrite = w_store;
          w_next  = w_load ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        ALUControl = w_alu_ctl;
        ALUSrc     = w_alu_src;
        RegWrite   = 1'b1;
        PcWrite    = 1'b1;
        MemToReg   = w_load;
        w_next     = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed bench for control_fsm. Each instruction is expanded
// into its expected per-cycle output timeline; a single compare process checks
// the DUT against that timeline and against a few literal spot values.
module tb_control_fsm;

  logic       clk;
  logic       rst;
  logic [8:0] inst;
  logic       BranchFlag;
  logic       overflow;
  logic       mem_ack;
  logic       MemToReg, PcSrc, ALUSrc, RegWrite, Jump;
  logic [2:0] ALUControl, AccControl;
  logic       PcWrite, MemRead, MemWrite, halted, ovf_flag;
  logic [7:0] retired;

  control_fsm dut (
    .clk(clk), .rst(rst), .inst(inst), .BranchFlag(BranchFlag),
    .overflow(overflow), .mem_ack(mem_ack), .MemToReg(MemToReg),
    .PcSrc(PcSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .Jump(Jump),
    .ALUControl(ALUControl), .AccControl(AccControl), .PcWrite(PcWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .halted(halted),
    .ovf_flag(ovf_flag), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       mtr, pcsrc, alusrc, regw, jump;
    logic [2:0] aluc, accc;
    logic       pcw, mrd, mwr, hlt, ovf;
    logic [7:0] ret;
  } outv_t;

  typedef struct { int id; string tag; outv_t v; } exp_t;
  typedef struct { int id; int sel; int val; string name; } lit_t;

  localparam int L_RET = 1, L_OVF = 2, L_HLT = 3, L_MRD = 4,
                 L_JMP = 5, L_REGW = 6, L_MWR = 7, L_CLR = 8;

  exp_t exp_q[$];
  lit_t lit_q[$];
  int   cyc_id = 0;
  int   n_vec  = 0;
  int   n_miss = 0;

  // reference state carried across instructions
  logic [7:0] m_ret;
  logic       m_ovf;

  function automatic outv_t dut_out();
    outv_t o;
    o.mtr = MemToReg; o.pcsrc = PcSrc; o.alusrc = ALUSrc; o.regw = RegWrite;
    o.jump = Jump; o.aluc = ALUControl; o.accc = AccControl; o.pcw = PcWrite;
    o.mrd = MemRead; o.mwr = MemWrite; o.hlt = halted; o.ovf = ovf_flag;
    o.ret = retired;
    return o;
  endfunction

  // one clock of stimulus plus its expected outputs
  task automatic cyc(input logic [8:0] iv, input logic ack, input logic bf,
                     input logic ov, input logic rs, input outv_t e,
                     input string tag);
    exp_t r;
    @(posedge clk); #1;
    inst = iv; mem_ack = ack; BranchFlag = bf; overflow = ov; rst = rs;
    cyc_id++;
    r.id = cyc_id; r.tag = tag; r.v = e;
    exp_q.push_back(r);
  endtask

  // literal check evaluated on the next applied cycle
  task automatic lit(input int sel, input int val, input string name);
    lit_t l;
    l.id = cyc_id + 1; l.sel = sel; l.val = val; l.name = name;
    lit_q.push_back(l);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; mem_ack = 1'b1; overflow = 1'b1; BranchFlag = 1'b1;
    m_ret = 8'd0; m_ovf = 1'b0;
  endtask

  // Expand one instruction into its cycle timeline; noise is driven on
  // inputs the unit must ignore. abort_c > 0 asserts rst in that cycle.
  task automatic run_instr(input string nm, input logic [8:0] ins,
                           input int n_mem, input logic bf, input logic ov,
                           input int abort_c);
    logic [2:0] op;
    bit         arith, ld, st, sy, hlt, acc, in_mem;
    logic [2:0] aluc;
    logic       src;
    int         len;
    outv_t      e;
    logic       ack, ovin, rs;
    logic [8:0] iv;
    op    = ins[8:6];
    arith = (op == 3'd0) || (op == 3'd1) || (op == 3'd6);
    ld    = (op == 3'd4);
    st    = (op == 3'd5);
    sy    = (op == 3'd7);
    hlt   = sy && (ins[5:0] == 6'd0);
    acc   = sy && (ins[5:3] == 3'b001);
    aluc  = (op == 3'd1) ? 3'b110 : (arith || ld || st) ? 3'b010 : 3'b000;
    src   = (op == 3'd6) || ld || st;
    len   = hlt ? 2 : ld ? 4 + n_mem : st ? 3 + n_mem : arith ? 4 : 3;
    for (int c = 1; c <= len; c++) begin
      e    = '0;
      ack  = 1'b1;
      ovin = 1'b1;
      iv   = (c == 1) ? ins : 9'($urandom);
      e.ret = m_ret;
      e.ovf = m_ovf;
      if (c >= 2) begin
        e.aluc   = aluc;
        e.alusrc = src;
      end
      if (c == 3) begin
        ovin = ov;
        if (op == 3'd2) begin e.jump = 1'b1; e.pcw = 1'b1; end
        if (op == 3'd3) begin e.pcsrc = bf; e.pcw = 1'b1; end
        if (sy) begin e.accc = acc ? ins[2:0] : 3'b000; e.pcw = 1'b1; end
      end
      in_mem = (ld || st) && (c >= 4) && (c <= 3 + n_mem);
      if (in_mem) begin
        ack   = (c == 3 + n_mem);
        e.mrd = ld;
        e.mwr = st;
        if (st && ack) e.pcw = 1'b1;
      end
      if ((c == len) && (arith || ld)) begin
        e.regw = 1'b1; e.pcw = 1'b1; e.mtr = ld;
      end
      rs = (c == abort_c);
      cyc(iv, ack, bf, ovin, rs, e, $sformatf("%s c%0d", nm, c));
      if (rs) begin
        m_ret = 8'd0; m_ovf = 1'b0;
        return;
      end
      if (e.pcw) m_ret = m_ret + 8'd1;
      if ((c == 3) && arith && ov) m_ovf = 1'b1;
    end
  endtask

  task automatic idle_halted(input int k);
    outv_t e;
    for (int i = 0; i < k; i++) begin
      e = '0; e.hlt = 1'b1; e.ret = m_ret; e.ovf = m_ovf;
      cyc(9'($urandom), 1'b1, 1'b1, 1'b1, 1'b0, e, $sformatf("HALT idle%0d", i));
    end
  endtask

  // compare process: timeline check every cycle, literal checks when due
  exp_t cur;
  lit_t curl;
  outv_t act_v;
  int act_i;
  int cnt_mrd = 0, cnt_jmp = 0, cnt_regw = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        cur = exp_q.pop_front();
        while (lit_q.size() != 0 && lit_q[0].id == cur.id) begin
          curl = lit_q.pop_front();
          if (curl.sel == L_CLR) begin
            cnt_mrd = 0; cnt_jmp = 0; cnt_regw = 0;
          end else begin
            case (curl.sel)
              L_RET:   act_i = int'(retired);
              L_OVF:   act_i = int'(ovf_flag);
              L_HLT:   act_i = int'(halted);
              L_MRD:   act_i = cnt_mrd;
              L_JMP:   act_i = cnt_jmp;
              L_REGW:  act_i = cnt_regw;
              L_MWR:   act_i = int'(MemWrite);
              default: act_i = -1;
            endcase
            n_vec++;
            if (act_i != curl.val) begin
              n_miss++;
              $display("FAIL %s: got %0d expected %0d", curl.name, act_i, curl.val);
            end
          end
        end
        act_v = dut_out();
        n_vec++;
        if (act_v !== cur.v) begin
          n_miss++;
          $display("FAIL %s: got mtr%b pcs%b src%b rw%b j%b alu%b acc%b pcw%b mr%b mw%b h%b ovf%b ret%0d | expected mtr%b pcs%b src%b rw%b j%b alu%b acc%b pcw%b mr%b mw%b h%b ovf%b ret%0d",
                   cur.tag, act_v.mtr, act_v.pcsrc, act_v.alusrc, act_v.regw, act_v.jump,
                   act_v.aluc, act_v.accc, act_v.pcw, act_v.mrd, act_v.mwr, act_v.hlt,
                   act_v.ovf, act_v.ret, cur.v.mtr, cur.v.pcsrc, cur.v.alusrc, cur.v.regw,
                   cur.v.jump, cur.v.aluc, cur.v.accc, cur.v.pcw, cur.v.mrd, cur.v.mwr,
                   cur.v.hlt, cur.v.ovf, cur.v.ret);
        end
        cnt_mrd  += (MemRead  === 1'b1) ? 1 : 0;
        cnt_jmp  += (Jump     === 1'b1) ? 1 : 0;
        cnt_regw += (RegWrite === 1'b1) ? 1 : 0;
      end
    end
  end

  // directed stimulus
  initial begin
    rst = 1'b1; inst = '0; BranchFlag = 1'b0; overflow = 1'b0; mem_ack = 1'b0;
    m_ret = 8'd0; m_ovf = 1'b0;

    do_reset();
    lit(L_RET, 0, "reset retired"); lit(L_HLT, 0, "reset halted");
    lit(L_OVF, 0, "reset ovf"); lit(L_CLR, 0, "");
    run_instr("ADD", 9'b000_001_010, 0, 1'b0, 1'b0, 0);
    lit(L_RET, 1, "ADD retired"); lit(L_REGW, 1, "ADD regwrite cycles");
    lit(L_CLR, 0, "");
    run_instr("LOAD", 9'b100_001_011, 3, 1'b0, 1'b0, 0);
    lit(L_MRD, 3, "LOAD memread cycles"); lit(L_RET, 2, "LOAD retired");
    lit(L_CLR, 0, "");
    run_instr("BR1", 9'b011_000_000, 0, 1'b1, 1'b0, 0);
    run_instr("BR0", 9'b011_000_000, 0, 1'b0, 1'b0, 0);
    lit(L_REGW, 0, "BRANCH regwrite cycles"); lit(L_RET, 4, "BRANCH retired");
    run_instr("SUB", 9'b001_001_001, 0, 1'b0, 1'b1, 0);
    run_instr("ADDI", 9'b110_000_101, 0, 1'b0, 1'b0, 0);
    run_instr("ACC", 9'b111_001_101, 0, 1'b0, 1'b0, 0);
    run_instr("NOP", 9'b111_010_000, 0, 1'b0, 1'b0, 0);
    run_instr("STORE", 9'b101_000_100, 1, 1'b0, 1'b0, 0);
    run_instr("LOAD1", 9'b100_000_001, 1, 1'b0, 1'b0, 0);
    lit(L_OVF, 1, "ovf sticky"); lit(L_RET, 10, "mix retired");
    run_instr("ADD2", 9'b000_011_100, 0, 1'b1, 1'b0, 0);

    do_reset();
    lit(L_OVF, 0, "ovf after rst"); lit(L_RET, 0, "retired after rst");
    lit(L_CLR, 0, "");
    for (int i = 0; i < 255; i++)
      run_instr("JUMP", 9'b010_010_011, 0, 1'b0, 1'b0, 0);
    lit(L_RET, 255, "retired 255");
    run_instr("JUMP", 9'b010_010_011, 0, 1'b0, 1'b0, 0);
    lit(L_RET, 0, "retired wrap"); lit(L_JMP, 256, "jump pulses");
    run_instr("HALT", 9'b111_000_000, 0, 1'b0, 1'b0, 0);
    lit(L_HLT, 1, "halted"); lit(L_CLR, 0, "");
    idle_halted(6);
    lit(L_RET, 0, "halt retired"); lit(L_JMP, 0, "halt jump pulses");
    lit(L_MRD, 0, "halt memread cycles");
    idle_halted(1);

    do_reset();
    run_instr("ADD3", 9'b000_000_000, 0, 1'b0, 1'b0, 0);
    run_instr("STOREABT", 9'b101_010_001, 5, 1'b0, 1'b0, 5);
    lit(L_MWR, 0, "memwrite after rst"); lit(L_RET, 0, "abort retired");
    lit(L_HLT, 0, "abort halted");
    run_instr("ADD4", 9'b000_000_000, 0, 1'b0, 1'b1, 0);

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
